// File: rtl/xillybus_mem_window.sv
// Seekable dual-port memory window for the Xillybus addressed-stream interface.
// Host side streams through an auto-incrementing pointer; the application side has its own port.
module xillybus_mem_window #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned WRAP_MODE = 1
) (
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic [ADDR_W-1:0] user_mem_addr,
    input  logic              user_mem_addr_update,
    input  logic              user_w_mem_wren,
    input  logic [DATA_W-1:0] user_w_mem_data,
    output logic              user_w_mem_full,
    input  logic              user_r_mem_rden,
    output logic [DATA_W-1:0] user_r_mem_data,
    output logic              user_r_mem_empty,
    output logic              user_r_mem_eof,
    input  logic [ADDR_W-1:0] app_addr,
    input  logic              app_wr_en,
    input  logic [DATA_W-1:0] app_wr_data,
    output logic [DATA_W-1:0] app_rd_data,
    output logic              app_collision,
    output logic [15:0]       host_wr_count
);

    localparam int unsigned    DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PtrEnd = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   ptr_q, ptr_d, ptr_inc;
    logic [DATA_W-1:0] rd_data_q, app_rd_q;
    logic              collision_q, collision_d;
    logic [15:0]       wr_count_q, wr_count_d;

    logic              at_end;
    logic              host_wr, host_rd;
    logic [ADDR_W-1:0] host_idx;

    assign at_end   = (WRAP_MODE == 0) && (ptr_q == PtrEnd);
    assign host_idx = ptr_q[ADDR_W-1:0];
    // Host accesses are suppressed in the reset cycle so reset leaves no trace in memory or data.
    assign host_wr  = user_w_mem_wren && !at_end && !bus_rst;
    assign host_rd  = user_r_mem_rden && !at_end && !bus_rst;

    always_comb begin
        ptr_inc = ptr_q + (ADDR_W + 1)'(1);
        if (WRAP_MODE != 0) begin
            ptr_inc[ADDR_W] = 1'b0;
        end
        ptr_d = ptr_q;
        if (user_mem_addr_update) begin
            ptr_d = {1'b0, user_mem_addr};
        end else if (host_wr || host_rd) begin
            ptr_d = ptr_inc;
        end
        collision_d = host_wr && app_wr_en && (app_addr == host_idx);
        wr_count_d  = wr_count_q + {15'd0, host_wr};
    end

    // Host write takes priority; the app write is dropped only when it targets the same word.
    always_ff @(posedge bus_clk) begin
        if (app_wr_en && !collision_d) begin
            mem_q[app_addr] <= app_wr_data;
        end
        if (host_wr) begin
            mem_q[host_idx] <= user_w_mem_data;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            ptr_q       <= '0;
            rd_data_q   <= '0;
            app_rd_q    <= '0;
            collision_q <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            app_rd_q    <= mem_q[app_addr];
            collision_q <= collision_d;
            wr_count_q  <= wr_count_d;
            if (host_rd) begin
                rd_data_q <= mem_q[host_idx];
            end
        end
    end

    assign user_w_mem_full  = at_end;
    assign user_r_mem_empty = at_end;
    assign user_r_mem_eof   = at_end;
    assign user_r_mem_data  = rd_data_q;
    assign app_rd_data      = app_rd_q;
    assign app_collision    = collision_q;
    assign host_wr_count    = wr_count_q;

endmodule

// File: tb/tb_xillybus_mem_window.sv
// Bench: two windows (saturating and wrapping) share stimulus and are checked against a
// behavioural model every cycle, plus directed scenarios with literal expectations.
module tb_xillybus_mem_window;

    logic        clk = 1'b0;
    logic        rst, upd, wren, rden, app_we;
    logic [4:0]  addr, app_addr;
    logic [31:0] wdata, app_wdata;

    logic [31:0] dut_r [2];
    logic [31:0] dut_a [2];
    logic        dut_full [2];
    logic        dut_empty [2];
    logic        dut_eof [2];
    logic        dut_coll [2];
    logic [15:0] dut_cnt [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit app_chk_en = 1'b0;
    logic [31:0] fillv [32];

    always #5 clk = ~clk;

    xillybus_mem_window #(.DATA_W(32), .ADDR_W(5), .WRAP_MODE(0)) u_sat (
        .bus_clk(clk), .bus_rst(rst),
        .user_mem_addr(addr), .user_mem_addr_update(upd),
        .user_w_mem_wren(wren), .user_w_mem_data(wdata), .user_w_mem_full(dut_full[0]),
        .user_r_mem_rden(rden), .user_r_mem_data(dut_r[0]),
        .user_r_mem_empty(dut_empty[0]), .user_r_mem_eof(dut_eof[0]),
        .app_addr(app_addr), .app_wr_en(app_we), .app_wr_data(app_wdata),
        .app_rd_data(dut_a[0]), .app_collision(dut_coll[0]), .host_wr_count(dut_cnt[0])
    );

    xillybus_mem_window #(.DATA_W(32), .ADDR_W(5), .WRAP_MODE(1)) u_wrap (
        .bus_clk(clk), .bus_rst(rst),
        .user_mem_addr(addr), .user_mem_addr_update(upd),
        .user_w_mem_wren(wren), .user_w_mem_data(wdata), .user_w_mem_full(dut_full[1]),
        .user_r_mem_rden(rden), .user_r_mem_data(dut_r[1]),
        .user_r_mem_empty(dut_empty[1]), .user_r_mem_eof(dut_eof[1]),
        .app_addr(app_addr), .app_wr_en(app_we), .app_wr_data(app_wdata),
        .app_rd_data(dut_a[1]), .app_collision(dut_coll[1]), .host_wr_count(dut_cnt[1])
    );

    // Model state, index 0 = saturating window, 1 = wrapping window.
    logic [31:0] mm [2][32];
    int unsigned pm [2];
    logic [31:0] rm [2];
    logic [31:0] am [2];
    logic        cm [2];
    int unsigned nm [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            bit endf, hw, hr;
            int unsigned idx;
            endf = (w == 0) && (pm[w] == 32);
            idx  = pm[w] % 32;
            hw   = !rst && wren && !endf;
            hr   = !rst && rden && !endf;
            am[w] = rst ? 32'd0 : mm[w][app_addr];
            if (rst) rm[w] = 32'd0;
            else if (hr) rm[w] = mm[w][idx];
            cm[w] = hw && app_we && (int'(app_addr) == idx);
            if (app_we && !cm[w]) mm[w][app_addr] = app_wdata;
            if (hw) mm[w][idx] = wdata;
            nm[w] = rst ? 0 : (nm[w] + (hw ? 1 : 0)) % 65536;
            if (rst) pm[w] = 0;
            else if (upd) pm[w] = addr;
            else if (hw || hr) pm[w] = (w == 1) ? (pm[w] + 1) % 32 : pm[w] + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int w = 0; w < 2; w++) begin
                logic flag;
                flag = (w == 0) && (pm[w] == 32);
                chk($sformatf("rdata[%0d]", w), dut_r[w], rm[w]);
                chk($sformatf("coll[%0d]", w), {31'd0, dut_coll[w]}, {31'd0, cm[w]});
                chk($sformatf("count[%0d]", w), {16'd0, dut_cnt[w]}, nm[w]);
                chk($sformatf("full[%0d]", w), {31'd0, dut_full[w]}, {31'd0, flag});
                chk($sformatf("empty[%0d]", w), {31'd0, dut_empty[w]}, {31'd0, flag});
                chk($sformatf("eof[%0d]", w), {31'd0, dut_eof[w]}, {31'd0, flag});
                if (app_chk_en) chk($sformatf("app_rd[%0d]", w), dut_a[w], am[w]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; upd = 1'b0; wren = 1'b0; rden = 1'b0; app_we = 1'b0;
    endtask

    task automatic both(input string name, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] exp);
        chk({name, "[0]"}, a0, exp);
        chk({name, "[1]"}, a1, exp);
    endtask

    initial begin
        idle();
        addr = '0; app_addr = '0; wdata = '0; app_wdata = '0;
        rst = 1'b1;
        step(); step();
        chk_en = 1'b1;
        both("rst_rdata", dut_r[0], dut_r[1], 32'd0);
        both("rst_count", {16'd0, dut_cnt[0]}, {16'd0, dut_cnt[1]}, 32'd0);
        chk("rst_full[0]", {31'd0, dut_full[0]}, 32'd0);
        idle();
        for (int a = 0; a < 32; a++) begin
            fillv[a] = $urandom;
            app_we = 1'b1; app_addr = 5'(a); app_wdata = fillv[a];
            step();
        end
        idle();
        step();
        app_chk_en = 1'b1;

        // Seek/write/seek/read round trip
        upd = 1'b1; addr = 5'd3; step(); idle();
        wren = 1'b1; wdata = 32'hA1; step(); wdata = 32'hA2; step(); wdata = 32'hA3; step();
        idle(); upd = 1'b1; addr = 5'd3; step(); idle();
        rden = 1'b1; step();
        both("rt_rd1", dut_r[0], dut_r[1], 32'hA1);
        chk("model_rd1", rm[1], 32'hA1);
        step(); both("rt_rd2", dut_r[0], dut_r[1], 32'hA2);
        step(); both("rt_rd3", dut_r[0], dut_r[1], 32'hA3);
        idle();
        both("rt_count", {16'd0, dut_cnt[0]}, {16'd0, dut_cnt[1]}, 32'd3);
        chk("model_count", nm[0], 32'd3);

        // Wrap versus saturate at the top of the window
        upd = 1'b1; addr = 5'd31; step(); idle();
        wren = 1'b1; wdata = 32'h11; step(); wdata = 32'h22; step(); idle();
        chk("sat_full", {31'd0, dut_full[0]}, 32'd1);
        chk("wrap_empty", {31'd0, dut_empty[1]}, 32'd0);
        chk("wrap_eof", {31'd0, dut_eof[1]}, 32'd0);
        chk("sat_count", {16'd0, dut_cnt[0]}, 32'd4);
        chk("wrap_count", {16'd0, dut_cnt[1]}, 32'd5);
        app_addr = 5'd31; step();
        both("wrap_m31", dut_a[0], dut_a[1], 32'h11);
        app_addr = 5'd0; step();
        chk("wrap_m0", dut_a[1], 32'h22);
        chk("sat_m0", dut_a[0], fillv[0]);

        // Saturating end-of-window and seek recovery
        upd = 1'b1; addr = 5'd30; step(); idle();
        wren = 1'b1; wdata = 32'h33; step(); wdata = 32'h44; step();
        chk("eow_full", {31'd0, dut_full[0]}, 32'd1);
        chk("eow_empty", {31'd0, dut_empty[0]}, 32'd1);
        chk("eow_eof", {31'd0, dut_eof[0]}, 32'd1);
        wdata = 32'h55; step(); idle();
        chk("eow_count", {16'd0, dut_cnt[0]}, 32'd6);
        app_addr = 5'd0; step();
        chk("eow_m0", dut_a[0], fillv[0]);
        chk("eow_still", {31'd0, dut_full[0]}, 32'd1);
        upd = 1'b1; addr = 5'd0; step(); idle();
        chk("eow_clear", {31'd0, dut_full[0] | dut_empty[0] | dut_eof[0]}, 32'd0);

        // Host/app collision on word 7
        upd = 1'b1; addr = 5'd7; step(); idle();
        wren = 1'b1; wdata = 32'h55; app_we = 1'b1; app_addr = 5'd7; app_wdata = 32'h77;
        step(); idle();
        both("coll_pulse", {31'd0, dut_coll[0]}, {31'd0, dut_coll[1]}, 32'd1);
        step();
        both("coll_end", {31'd0, dut_coll[0]}, {31'd0, dut_coll[1]}, 32'd0);
        both("coll_data", dut_a[0], dut_a[1], 32'h55);

        // Same-cycle write and read: read-first, single increment
        upd = 1'b1; addr = 5'd4; app_we = 1'b1; app_addr = 5'd4; app_wdata = 32'h10;
        step(); idle();
        wren = 1'b1; wdata = 32'h99; rden = 1'b1; step(); idle();
        both("rw_old", dut_r[0], dut_r[1], 32'h10);
        step();
        both("rw_new", dut_a[0], dut_a[1], 32'h99);
        rden = 1'b1; step(); idle();
        both("rw_ptr5", dut_r[0], dut_r[1], 32'hA3);

        // Reset in the middle of a read burst with a seek pending
        rden = 1'b1; step();
        rst = 1'b1; upd = 1'b1; addr = 5'd9; step(); idle();
        both("mr_rdata", dut_r[0], dut_r[1], 32'd0);
        both("mr_app", dut_a[0], dut_a[1], 32'd0);
        both("mr_count", {16'd0, dut_cnt[0]}, {16'd0, dut_cnt[1]}, 32'd0);
        both("mr_coll", {31'd0, dut_coll[0]}, {31'd0, dut_coll[1]}, 32'd0);
        rden = 1'b1; step(); idle();
        chk("mr_ptr0[0]", dut_r[0], fillv[0]);
        chk("mr_ptr0[1]", dut_r[1], 32'h55);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            upd       = ($urandom_range(0, 7) == 0);
            addr      = 5'($urandom);
            wren      = 1'($urandom);
            rden      = 1'($urandom);
            wdata     = $urandom;
            app_we    = ($urandom_range(0, 2) == 0);
            app_addr  = ($urandom_range(0, 3) == 0) ? 5'(pm[$urandom_range(0, 1)] % 32)
                                                    : 5'($urandom);
            app_wdata = $urandom;
            step();
        end
        idle();
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
